// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-organised data memory: byte/half/word accesses,
// read-modify-write partial stores. Optional misalignment check: MEM_ACCESS_MISALIGN_CHECK_EN.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int STORE_RSP  = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_write_data,
  input  logic [31:0]           mem_read_data
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD     = 3'd1;
  localparam logic [2:0] S_WR     = 3'd2;
  localparam logic [2:0] S_RMW_RD = 3'd3;
  localparam logic [2:0] S_RMW_WR = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd5;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  localparam logic STORE_RSP_EN = (STORE_RSP != 0);

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [1:0]            size_q;
  logic                  signed_q;
  logic                  rsp_valid_q;
  logic [31:0]           rsp_rdata_q;
  logic                  misaligned;

  // Pick the addressed lane(s) out of a memory word and extend to 32 bits.
  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] lane,
                                          input logic [1:0] size, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] shifted;
    shifted = word >> {lane, 3'b000};
    b = shifted[7:0];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: extract = {{24{sgn & b[7]}}, b};
      SZ_HALF: extract = {{16{sgn & h[15]}}, h};
      default: extract = word;
    endcase
  endfunction

  // Insert right-aligned store data into the addressed lane(s), keeping the rest.
  function automatic logic [31:0] merge(input logic [31:0] word, input logic [31:0] data,
                                        input logic [1:0] lane, input logic [1:0] size);
    logic [31:0] mask;
    logic [4:0]  shamt;
    case (size)
      SZ_BYTE: begin
        shamt = {lane, 3'b000};
        mask  = 32'h0000_00FF << shamt;
      end
      SZ_HALF: begin
        shamt = {lane[1], 4'b0000};
        mask  = 32'h0000_FFFF << shamt;
      end
      default: begin
        shamt = 5'd0;
        mask  = 32'hFFFF_FFFF;
      end
    endcase
    merge = (word & ~mask) | ((data << shamt) & mask);
  endfunction

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
  // Size 2'b11 is a word, so req_size[1] covers both word encodings.
  assign misaligned = ((req_size == SZ_HALF) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= SZ_BYTE;
      signed_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            size_q   <= req_size;
            signed_q <= req_signed;
            if (misaligned)     state <= S_ERR;
            else if (!req_write) state <= S_RD;
            else if (req_size[1]) state <= S_WR;
            else                 state <= S_RMW_RD;
          end
        end
        S_RD: begin
          rsp_rdata_q <= extract(mem_read_data, addr_q[1:0], size_q, signed_q);
          rsp_valid_q <= 1'b1;
          state       <= S_IDLE;
        end
        S_WR: begin
          rsp_valid_q <= STORE_RSP_EN;
          state       <= S_IDLE;
        end
        S_RMW_RD: begin
          wdata_q <= merge(mem_read_data, wdata_q, addr_q[1:0], size_q);
          state   <= S_RMW_WR;
        end
        S_RMW_WR: begin
          rsp_valid_q <= STORE_RSP_EN;
          state       <= S_IDLE;
        end
        S_ERR: begin
          rsp_valid_q <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
  logic rsp_err_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rsp_err_q <= 1'b0;
    else       rsp_err_q <= (state == S_ERR);
  end
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Write enable comes straight from the state register, so reset kills it at once.
  assign mem_write      = (state == S_WR) || (state == S_RMW_WR);
  assign mem_address    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign mem_write_data = wdata_q;
  assign req_ready      = (state == S_IDLE);
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;

endmodule
